// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one sequential shift-and-add multiplier
// between two requesters; returns a 2N-bit product with a one-cycle valid pulse.
module mult_share_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           valid0,
  output logic           valid1,
  output logic [2*N-1:0] p,
  output logic           busy,
  output logic           owner
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_reg;
  logic [N-1:0]     mcand_reg;
  logic [N-1:0]     hi_reg;
  logic [N-1:0]     lo_reg;
  logic [CW-1:0]    cnt_reg;
  logic             last_reg;
  logic             owner_reg;
  logic [1:0]       gnt_reg;
  logic [1:0]       valid_reg;
  logic [2*N-1:0]   p_reg;

  logic [1:0]       req_v;
  logic [N-1:0]     a_v [2];
  logic [N-1:0]     b_v [2];
  logic             win;
  logic [N:0]       sum_next;
  logic [2*N-1:0]   shift_next;

  assign req_v = {req1, req0};
  assign a_v[0] = a0;
  assign a_v[1] = a1;
  assign b_v[0] = b0;
  assign b_v[1] = b1;

  // On a tie the requester that was not served last wins; otherwise the lone one.
  assign win = (req_v == 2'b11) ? ~last_reg : req_v[1];

  // The carry lands in the top bit of the shifted accumulator, so the
  // carry-out register of the classic form is always zero and is not kept.
  assign sum_next   = lo_reg[0] ? ({1'b0, hi_reg} + {1'b0, mcand_reg}) : {1'b0, hi_reg};
  assign shift_next = {sum_next, lo_reg[N-1:1]};

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
      owner_reg <= 1'b0;
      gnt_reg   <= '0;
      valid_reg <= '0;
      p_reg     <= '0;
    end else begin
      gnt_reg   <= '0;
      valid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_v) begin
            mcand_reg    <= a_v[win];
            lo_reg       <= b_v[win];
            hi_reg       <= '0;
            cnt_reg      <= '0;
            last_reg     <= win;
            owner_reg    <= win;
            gnt_reg[win] <= 1'b1;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          {hi_reg, lo_reg} <= shift_next;
          cnt_reg          <= cnt_reg + CW'(1);
          if (cnt_reg == CNT_LAST) begin
            p_reg                <= shift_next;
            valid_reg[owner_reg] <= 1'b1;
            state_reg            <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt0   = gnt_reg[0];
  assign gnt1   = gnt_reg[1];
  assign valid0 = valid_reg[0];
  assign valid1 = valid_reg[1];
  assign p      = p_reg;
  assign busy   = (state_reg == CALC);
  assign owner  = owner_reg;

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Controller that shares one sequential N-bit shift-and-add multiplier between two requesters. It arbitrates round-robin, latches the winner's operands, runs the adder for N iterations, then returns a 2N-bit product with a one-cycle valid pulse to the winner. It sits between the operand registers of two front-end ports and the decimal display/product register path of the lab top level. It replaces two combinational array multipliers with one shared adder.

## Interface
- N, 8, operand width; product width is 2N
- clk  in  1  rising-edge clock
- clr  in  1  reset; synchronous, active-high
- req0  in  1  requester 0 wants a multiply; level, held until gnt0 seen
- a0, b0  in  N  requester 0 operands; stable while req0 high
- req1  in  1  requester 1 request, same rules as req0
- a1, b1  in  N  requester 1 operands
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, operands captured
- valid0, valid1  out  1  one-cycle pulse: p holds this requester's result
- p  out  2N  product of the last completed operation; held between completions
- busy  out  1  multiplier occupied, state != IDLE
- owner  out  1  index of the requester currently or last served

## Operation
- FSM states: IDLE and CALC. All outputs are registered.
- Internal registers: mcand (N), acc {cout, hi[N-1:0], lo[N-1:0]}, iteration counter cnt (log2 N bits), rr pointer last (1 bit).
- IDLE, at an edge with any req high:
  - Winner: if only one req is high, that requester wins. If both are high, the requester != last wins.
  - Effects: mcand <= a_w; lo <= b_w; hi <= 0; cnt <= 0; last <= w; owner <= w; gnt_w <= 1; state <= CALC.
- CALC, each edge:
  - If lo[0] = 1, {c, hi} = hi + mcand (N-bit add with carry out); otherwise c = 0 and hi is unchanged.
  - Then acc <= {c, hi, lo} >> 1.
  - cnt <= cnt + 1.
- CALC, at the edge where cnt = N-1:
  - p <= the shifted result of this final iteration, {hi, lo}.
  - valid_owner <= 1; state <= IDLE.
- There is no early exit. Zero operands still take N iterations.
- Requests arriving while state = CALC are not sampled. A req held high is served at the first IDLE edge.
- A requester that keeps req high after gnt issues a new request. That request is accepted at the next IDLE edge, subject to round-robin.
- Reset values: state IDLE; p = 0; gnt0/1 = 0; valid0/1 = 0; busy = 0; owner = 0; cnt = 0; acc = 0; last = 1, so req0 wins the first tie.
- Reset during CALC aborts the operation:
  - No valid pulse is produced.
  - p is cleared to 0.
  - Requests sampled on the reset edge are ignored.

## Timing
- Request sampled at edge k gives these responses:
  - gnt_w is high for the cycle after edge k.
  - busy is high from after edge k through edge k+N.
  - valid_w is high for the cycle after edge k+N, together with the new p.
- Latency from accept edge to valid: N cycles, which is 8 for the default.
- Throughput: at most one operation per N+1 cycles. Next accept is at edge k+N+1, the edge on which valid clears.
- gnt and valid are never high together for the same operation. At most one of gnt0/gnt1 is high in any cycle, and likewise for valid0/valid1.
- Both requesters held high continuously alternate 0, 1, 0, 1 …, with accept edges N+1 cycles apart.

## Test plan
- Reset, then req0=1, a0=12, b0=10 for one edge:
  - gnt0 is high in the next cycle.
  - valid0 is high 8 cycles after the accept edge, with p = 120.
  - valid1 stays 0 throughout.
- req0 with a0=255, b0=255:
  - p = 65025 (0xFE01) on valid0.
  - Then a0=0, b0=200 gives p = 0, still after 8 cycles.
- req0 and req1 asserted together and held, with a0=3, b0=5 and a1=7, b1=9:
  - Grant order is 0, 1, 0, 1.
  - Products are 15 and 63 on the matching valid lines.
  - Accept edges are 9 cycles apart.
- req1 alone (a1=100, b1=100), then req0 raised 3 cycles later:
  - req0 is ignored until busy drops.
  - valid1 gives p = 10000.
  - gnt0 follows on the edge where valid1 clears.
- clr asserted 4 cycles into an operation (a0=20, b0=20):
  - All outputs read their reset values after that edge, and no valid pulse appears.
  - A new req0 then completes normally with p = 400.
- Exhaustive/random check of 2000 operand pairs against a*b, both requesters interleaved:
  - Every gnt is matched by exactly one valid to the same owner.
  - p is unchanged between completions.
